seq_mul_unit: RTL and testbench
===============================

Name: seq_mul_unit

Overview:
- Multi-cycle RV32M multiply unit for the EX stage; covers MUL, MULH, MULHSU and MULHU.
- Uses a shift-and-add datapath: one N-bit ripple-carry add (with carry out) per iteration into a 2N-bit product register.
- Takes operands from ID/EX over a valid/ready handshake and holds the result for EX/MEM until it is accepted.
- Supports pipeline flush (kill) at any point.

Parameters:
- N, 32, operand and result width in bits.
- TAG_W, 5, width of the destination-register tag carried through with the operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit can accept a new operation.
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- operand_a  in  N  rs1 value.
- operand_b  in  N  rs2 value.
- tag_in  in  TAG_W  rd index.
- kill  in  1  flush: abort the current operation and drop any result.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  N  selected product half.
- tag_out  out  TAG_W  tag captured at accept.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; tag_out=0; count=0; product register=0.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE). Accept condition: in_valid & in_ready & ~kill.
- On accept:
  - Latch op and tag.
  - sa = op in {MULH, MULHSU}; sb = op==MULH.
  - Take magnitudes: a_mag = |a| if sa&a[N-1], else a; same rule for b with sb.
  - neg = (sa&a[N-1]) ^ (sb&b[N-1]).
  - P = {N'b0, b_mag}; count=0; go to CALC.
- CALC, per cycle:
  - If P[0]: {c,s} = P[2N-1:N] + a_mag; otherwise {c,s} = {0, P[2N-1:N]}.
  - P <= {c, s, P[N-1:1]}; count++.
  - After N CALC cycles (count==N-1 on the edge), go to FIX.
- FIX:
  - If neg, P <= ~P + 1 (2N-bit two's complement).
  - result <= MUL ? low half : high half, taken from the sign-corrected value; tag_out <= latched tag.
  - Go to DONE with out_valid=1.
- Latency: out_valid rises N+1 cycles after the accepting edge (33 for N=32).
- DONE:
  - result, tag_out and out_valid are held stable until out_ready=1.
  - On out_valid & out_ready: return to IDLE, out_valid=0.
  - The next op can be accepted one cycle later, so throughput is one op per N+3 cycles minimum.
- kill:
  - In CALC, FIX or DONE: next edge goes to IDLE and out_valid=0. result keeps its stale value, which is don't-care.
  - In IDLE: blocks accept even if in_valid=1.
  - kill together with out_ready in DONE: the result counts as dropped. The consumer must ignore it, since kill has priority.
- Boundary cases:
  - MUL: low half identical for all signedness.
  - Most-negative operands: magnitude 2^(N-1) is exact in N unsigned bits, so no overflow.
  - Zero operand: product 0, and neg is irrelevant because ~0+1 = 0 in 2N bits.
- Reset mid-operation: immediate return to reset values; no result is produced.
- in_valid while busy: ignored; the producer must hold it until in_ready.

Test Plan:
- MULHU 0xFFFFFFFF*0xFFFFFFFF: out_valid exactly 33 cycles after accept; result=0xFFFFFFFE; MUL of the same operands gives 0x00000001.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULH 0xFFFFFFFF*0xFFFFFFFF (-1*-1) -> 0x00000000. MULH 7*-3 -> 0xFFFFFFFF, and MUL 7*-3 -> 0xFFFFFFEB.
- MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF (unsigned): result=0xFFFFFFFF; MULHSU 0*0x12345678 -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. result and tag_out (e.g. 5'd17) must stay stable; in_ready=0 throughout; raising out_ready returns to IDLE next edge.
- kill at CALC count=10: out_valid never rises and in_ready=1 next cycle. A new op (MUL 3*4) then returns 12 with its own tag. kill together with in_valid in IDLE must not accept the op.
- rst_n pulsed low mid-CALC (asynchronously, between edges): outputs go to reset values immediately. After release, MUL 0x0001_0000*0x0001_0000 -> 0x00000000 and MULHU of the same -> 0x00000001.

Source files
------------

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: multi-cycle shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) with handshake and flush
module seq_mul_unit #(
  parameter int N = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [N-1:0]     operand_a,
  input  logic [N-1:0]     operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic [TAG_W-1:0] tag_out
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2*N-1:0] p, corr;
  logic [N-1:0] a_mag, a_abs, b_abs;
  logic [N:0] sum;
  logic [CW-1:0] count;
  logic [1:0] op_q;
  logic [TAG_W-1:0] tag_q;
  logic neg, sa, sb, neg_a, neg_b, accept, last;
  assign sa = (op == 2'b01) || (op == 2'b10);
  assign sb = op == 2'b01;
  assign neg_a = sa & operand_a[N-1];
  assign neg_b = sb & operand_b[N-1];
  assign a_abs = neg_a ? -operand_a : operand_a;
  assign b_abs = neg_b ? -operand_b : operand_b;
  assign accept = in_valid & in_ready & ~kill;
  assign last = count == CW'(N - 1);
  // one ripple add per iteration; the carry becomes the new top bit after the shift
  assign sum = {1'b0, p[2*N-1:N]} + {1'b0, p[0] ? a_mag : {N{1'b0}}};
  assign corr = neg ? -p : p;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = kill ? IDLE :
               state == IDLE ? (accept ? CALC : IDLE) :
               state == CALC ? (last ? FIX : CALC) :
               state == FIX  ? DONE :
               (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      a_mag <= '0;
      neg <= 1'b0;
      count <= '0;
      op_q <= '0;
      tag_q <= '0;
      result <= '0;
      tag_out <= '0;
    end else if (accept) begin
      op_q <= op;
      tag_q <= tag_in;
      a_mag <= a_abs;
      neg <= neg_a ^ neg_b;
      p <= {{N{1'b0}}, b_abs};
      count <= '0;
    end else if (state == CALC && !kill) begin
      p <= {sum, p[N-1:1]};
      count <= count + CW'(1);
    end else if (state == FIX && !kill) begin
      p <= corr;
      result <= op_q == 2'b00 ? corr[N-1:0] : corr[2*N-1:N];
      tag_out <= tag_q;
    end
  end
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: table-driven check of seq_mul_unit plus backpressure, kill and async reset sequences
module tb_seq_mul_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0] tag_in = '0;
  logic kill = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0] tag_out;
  int tests = 0;
  int fails = 0;

  seq_mul_unit #(.N(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .tag_in(tag_in),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] tag;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic [31:0] r, output logic [4:0] tg,
                        output int lat);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; tag_in = t; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    r = result;
    tg = tag_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    vec_t v[12];
    logic [31:0] r, r0;
    logic [4:0] tg, tg0;
    int lat;
    int seen;
    v[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    v[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0001};
    v[2]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000};
    v[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000};
    v[4]  = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFF};
    v[5]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd6,  32'hFFFF_FFEB};
    v[6]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF};
    v[7]  = '{2'b10, 32'h0000_0000, 32'h1234_5678, 5'd8,  32'h0000_0000};
    v[8]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'hC000_0000};
    v[9]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 5'd10, 32'hFFFF_FFFF};
    v[10] = '{2'b00, 32'h8000_0000, 32'h0000_0001, 5'd11, 32'h8000_0000};
    v[11] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 5'd31, 32'h0000_0001};

    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset tag_out", 32'(tag_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].tag, r, tg, lat);
      chk($sformatf("vec%0d result", i), r, v[i].exp);
      chk($sformatf("vec%0d tag", i), 32'(tg), 32'(v[i].tag));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
    end

    // backpressure: hold the result for 10 cycles
    @(negedge clk);
    op = 2'b11; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; tag_in = 5'd17; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp latency", 32'(lat), 32'd33);
    r0 = result;
    tg0 = tag_out;
    chk("bp result", r0, 32'hFFFF_FFFE);
    chk("bp tag", 32'(tg0), 32'd17);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp hold result", result, r0);
      chk("bp hold tag", 32'(tag_out), 32'(tg0));
      chk("bp hold out_valid", 32'(out_valid), 32'd1);
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);

    // kill at CALC count 10
    @(negedge clk);
    op = 2'b11; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0; tag_in = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("kill busy in_ready", 32'(in_ready), 32'd0);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("kill no out_valid", 32'(seen), 32'd0);
    run_op(2'b00, 32'd3, 32'd4, 5'd9, r, tg, lat);
    chk("after kill result", r, 32'd12);
    chk("after kill tag", 32'(tg), 32'd9);
    chk("after kill latency", 32'(lat), 32'd33);

    // kill with in_valid in IDLE must not accept
    @(negedge clk);
    op = 2'b00; operand_a = 32'd5; operand_b = 32'd5; tag_in = 5'd1; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; kill = 1'b0;
    chk("idle kill in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("idle kill no out_valid", 32'(seen), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    op = 2'b11; operand_a = 32'hFFFF_FFFF; operand_b = 32'h0000_0003; tag_in = 5'd12; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst tag_out", 32'(tag_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("async rst no result", 32'(seen), 32'd0);
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd20, r, tg, lat);
    chk("post rst MUL", r, 32'h0000_0000);
    chk("post rst MUL tag", 32'(tg), 32'd20);
    run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd21, r, tg, lat);
    chk("post rst MULHU", r, 32'h0000_0001);
    chk("post rst MULHU latency", 32'(lat), 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
